// File: rtl/pcie_fifo_pkg.sv
// ----------------------------------------------------------------------------
// pcie_fifo_pkg
// Purpose : Constants and helper functions shared by the PCIe RX FIFOs
//           (command FIFO, TLP tag FIFO and completion FIFO).
// Contents: clog2()      - ceiling log2 for sizing counters and addresses
//           ptr_width()  - pointer width: address bits plus one wrap bit
//           LP_CMD_*     - default geometry of the RX command FIFO
// ----------------------------------------------------------------------------
package pcie_fifo_pkg;

  // Default geometry of the RX command FIFO.
  localparam int LP_CMD_DATA_WIDTH   = 46;
  localparam int LP_CMD_DEPTH_WIDTH  = 5;
  localparam int LP_CMD_ALLOC_WIDTH  = 1;
  localparam int LP_CMD_AFULL_MARGIN = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // The extra MSB is the wrap bit. It tells full apart from empty when the
  // address bits of the two pointers are equal.
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage : pcie_fifo_pkg

// File: rtl/pcie_sdp_ram.sv
// ----------------------------------------------------------------------------
// pcie_sdp_ram
// Purpose : Inferred simple-dual-port RAM. It has one write port and one
//           synchronous read port that is enabled on every cycle.
//           The read is read-first: when the write and the read hit the same
//           address on the same edge, the read returns the old contents.
// Ports   : clk        - clock
//           i_wr_en    - write strobe
//           i_wr_addr  - write address (AW bits)
//           i_wr_data  - write data (DW bits)
//           i_rd_addr  - read address, sampled on every edge
//           o_rd_data  - registered read data
// ----------------------------------------------------------------------------
module pcie_sdp_ram #(
  parameter int DW = 46,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rd_data;

  // Both ports sit in one process with non-blocking assignments.
  // This gives read-first behaviour and maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule : pcie_sdp_ram

// File: rtl/pcie_cmd_fwft_fifo.sv
// ----------------------------------------------------------------------------
// pcie_cmd_fwft_fifo
// Purpose : Single-clock, first-word-fall-through command buffer that sits
//           between the TLP RX parser and the command consumers.
//           Full and empty are tracked in allocation units of
//           2**P_FIFO_ALLOC_WIDTH entries.
// Ports   : clk            - clock, all logic on posedge
//           rst            - synchronous active-high reset
//           flush          - synchronous clear (pointers only)
//           wr_en, wr_data - push one entry
//           full_n         - 0 when no allocation unit is free
//           almost_full_n  - 0 when free entries <= P_AFULL_MARGIN
//           rd_en          - pop the head entry
//           rd_data        - head entry, valid while empty_n=1
//           empty_n        - 1 when at least one complete unit is visible
//           occupancy      - visible entries (rear_vis - front)
//           wr_ovf         - one-cycle pulse: a push was rejected
//           rd_udf         - one-cycle pulse: a pop was rejected
// ----------------------------------------------------------------------------
module pcie_cmd_fwft_fifo
  import pcie_fifo_pkg::*;
#(
  parameter int P_FIFO_DATA_WIDTH  = LP_CMD_DATA_WIDTH,
  parameter int P_FIFO_DEPTH_WIDTH = LP_CMD_DEPTH_WIDTH,
  parameter int P_FIFO_ALLOC_WIDTH = LP_CMD_ALLOC_WIDTH,
  parameter int P_AFULL_MARGIN     = LP_CMD_AFULL_MARGIN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [P_FIFO_DATA_WIDTH-1:0]  wr_data,
  output logic                          full_n,
  output logic                          almost_full_n,
  input  logic                          rd_en,
  output logic [P_FIFO_DATA_WIDTH-1:0]  rd_data,
  output logic                          empty_n,
  output logic [P_FIFO_DEPTH_WIDTH:0]   occupancy,
  output logic                          wr_ovf,
  output logic                          rd_udf
);

  localparam int LP_PTR_W = ptr_width(P_FIFO_DEPTH_WIDTH);
  localparam int LP_AW    = P_FIFO_DEPTH_WIDTH;
  localparam int LP_UW    = P_FIFO_ALLOC_WIDTH;
  localparam logic [LP_PTR_W-1:0] LP_DEPTH  = LP_PTR_W'(1) << P_FIFO_DEPTH_WIDTH;
  localparam logic [LP_PTR_W-1:0] LP_MARGIN = LP_PTR_W'(P_AFULL_MARGIN);

  logic [LP_PTR_W-1:0] r_front;
  logic [LP_PTR_W-1:0] r_rear;
  logic [LP_PTR_W-1:0] r_rear_vis;
  logic                r_wr_ovf;
  logic                r_rd_udf;

  logic                w_full_n;
  logic                w_empty_n;
  logic                w_push;
  logic                w_pop;
  logic [LP_PTR_W-1:0] w_front_inc;
  logic [LP_PTR_W-1:0] w_rear_inc;
  logic [LP_PTR_W-1:0] w_used;
  logic [LP_PTR_W-1:0] w_free;
  logic [LP_AW-1:0]    w_rd_addr;

  // Full: the wrap bits differ and the in-ring unit indices match, so the
  // producer has lapped the consumer by one whole ring.
  assign w_full_n = ~((r_rear[LP_PTR_W-1] != r_front[LP_PTR_W-1]) &&
                      (r_rear[LP_PTR_W-2:LP_UW] == r_front[LP_PTR_W-2:LP_UW]));

  // Empty is judged against rear_vis, not rear. A unit completed on this
  // edge stays hidden until the RAM read port has had one edge to fetch it.
  // Per-entry pops inside the head unit keep front in the same unit, so
  // the head unit remains visible until its last entry is popped.
  assign w_empty_n = (r_rear_vis[LP_PTR_W-1:LP_UW] != r_front[LP_PTR_W-1:LP_UW]);

  // Flush suppresses both transfers, so it cannot raise an error pulse.
  assign w_push = wr_en & w_full_n  & ~flush;
  assign w_pop  = rd_en & w_empty_n & ~flush;

  assign w_front_inc = r_front + LP_PTR_W'(1);
  assign w_rear_inc  = r_rear  + LP_PTR_W'(1);

  // Almost-full counts entries already written, including ones not yet
  // visible. This gives the producer back-pressure as early as possible.
  assign w_used = r_rear - r_front;
  assign w_free = LP_DEPTH - w_used;

  // FWFT: the read address looks one entry ahead when a pop happens. The
  // registered RAM output then already holds the new head after the edge.
  assign w_rd_addr = w_pop ? w_front_inc[LP_AW-1:0] : r_front[LP_AW-1:0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_front    <= '0;
      r_rear     <= '0;
      r_rear_vis <= '0;
    end else begin
      r_rear_vis <= r_rear;
      if (w_push) begin
        r_rear <= w_rear_inc;
      end
      if (w_pop) begin
        r_front <= w_front_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ovf <= 1'b0;
      r_rd_udf <= 1'b0;
    end else begin
      r_wr_ovf <= wr_en & ~w_full_n  & ~flush;
      r_rd_udf <= rd_en & ~w_empty_n & ~flush;
    end
  end

  pcie_sdp_ram #(
    .DW (P_FIFO_DATA_WIDTH),
    .AW (LP_AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_rear[LP_AW-1:0]),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (rd_data)
  );

  assign full_n        = w_full_n;
  assign almost_full_n = (w_free > LP_MARGIN);
  assign empty_n       = w_empty_n;
  assign occupancy     = r_rear_vis - r_front;
  assign wr_ovf        = r_wr_ovf;
  assign rd_udf        = r_rd_udf;

endmodule : pcie_cmd_fwft_fifo

// File: tb/tb_pcie_cmd_fwft_fifo.sv
// ----------------------------------------------------------------------------
// tb_pcie_cmd_fwft_fifo
// Directed bench for the FWFT command FIFO in its default geometry:
// 46-bit entries, 32 deep, 2 entries per allocation unit, margin 4.
// Inputs change 1 time unit after a rising edge. Outputs are checked at
// that same point.
// ----------------------------------------------------------------------------
module tb_pcie_cmd_fwft_fifo;

  localparam int DW = 46;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full_n;
  logic          almost_full_n;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty_n;
  logic [5:0]    occupancy;
  logic          wr_ovf;
  logic          rd_udf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcie_cmd_fwft_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full_n        (full_n),
    .almost_full_n (almost_full_n),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty_n       (empty_n),
    .occupancy     (occupancy),
    .wr_ovf        (wr_ovf),
    .rd_udf        (rd_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_full_n"},  64'(full_n),        64'd1);
    chk({tag, "_afull_n"}, 64'(almost_full_n), 64'd1);
    chk({tag, "_empty_n"}, 64'(empty_n),       64'd0);
    chk({tag, "_occ"},     64'(occupancy),     64'd0);
    chk({tag, "_wr_ovf"},  64'(wr_ovf),        64'd0);
    chk({tag, "_rd_udf"},  64'(rd_udf),        64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    step();
    step();
    chk_reset_state("reset");
    $display("T0 reset: checks=%0d failures=%0d", checks, failures);

    // T1: write two entries; the unit becomes visible one edge later.
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 46'h1;
    step();                                   // edge 1
    chk("t1_empty_e1", 64'(empty_n), 64'd0);
    wr_data = 46'h2;
    step();                                   // edge 2
    chk("t1_empty_e2", 64'(empty_n), 64'd0);
    wr_en = 1'b0;
    step();                                   // edge 3
    chk("t1_empty_e3", 64'(empty_n),   64'd1);
    chk("t1_rd_data",  64'(rd_data),   64'h1);
    chk("t1_occ",      64'(occupancy), 64'd2);
    rd_en = 1'b1;
    step();
    chk("t1_rd_data2", 64'(rd_data),   64'h2);
    chk("t1_occ1",     64'(occupancy), 64'd1);
    step();
    rd_en = 1'b0;
    chk("t1_empty_end", 64'(empty_n), 64'd0);
    $display("T1 two-entry latency: checks=%0d failures=%0d", checks, failures);

    // T2: fill all 32 entries, then try a 33rd write.
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_data = DW'(46'h100 + i);
      step();
      if (i == 26) chk("t2_afull_27", 64'(almost_full_n), 64'd1);
      if (i == 27) chk("t2_afull_28", 64'(almost_full_n), 64'd0);
      if (i == 30) chk("t2_full_31",  64'(full_n),        64'd1);
      if (i == 31) chk("t2_full_32",  64'(full_n),        64'd0);
    end
    wr_data = 46'hDEAD;
    step();
    chk("t2_wr_ovf", 64'(wr_ovf), 64'd1);
    wr_en = 1'b0;
    step();
    chk("t2_wr_ovf_off", 64'(wr_ovf),    64'd0);
    chk("t2_occ_full",   64'(occupancy), 64'd32);
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t2_drain_%0d", i), 64'(rd_data), 64'h100 + 64'(i));
      step();
    end
    rd_en = 1'b0;
    chk("t2_empty_end", 64'(empty_n), 64'd0);
    $display("T2 fill/overflow: checks=%0d failures=%0d", checks, failures);

    // T3: prefill 4 entries, then push+pop for 100 cycles across the wrap.
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = DW'(46'h200 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("t3_occ_pre", 64'(occupancy), 64'd4);
    for (int k = 0; k < 100; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(46'h204 + k);
      chk($sformatf("t3_rd_%0d", k), 64'(rd_data), 64'h200 + 64'(k));
      step();
      chk($sformatf("t3_occ_%0d", k), 64'(occupancy), 64'd3);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("t3_occ_post", 64'(occupancy), 64'd4);
    rd_en = 1'b1;
    for (int k = 100; k < 104; k++) begin
      chk($sformatf("t3_tail_%0d", k), 64'(rd_data), 64'h200 + 64'(k));
      step();
    end
    rd_en = 1'b0;
    chk("t3_empty_end", 64'(empty_n), 64'd0);
    $display("T3 streaming: checks=%0d failures=%0d", checks, failures);

    // T4: pop on an empty FIFO, then a normal pair.
    rd_en = 1'b1;
    step();
    chk("t4_rd_udf", 64'(rd_udf), 64'd1);
    rd_en = 1'b0;
    step();
    chk("t4_rd_udf_off", 64'(rd_udf),    64'd0);
    chk("t4_occ",        64'(occupancy), 64'd0);
    wr_en = 1'b1; wr_data = 46'h55;
    step();
    wr_data = 46'h66;
    step();
    wr_en = 1'b0;
    step();
    chk("t4_empty_n", 64'(empty_n), 64'd1);
    chk("t4_rd_a",    64'(rd_data), 64'h55);
    rd_en = 1'b1;
    step();
    chk("t4_rd_b", 64'(rd_data), 64'h66);
    step();
    rd_en = 1'b0;
    chk("t4_empty_end", 64'(empty_n), 64'd0);
    $display("T4 underflow: checks=%0d failures=%0d", checks, failures);

    // T5: half-full, then flush with write and read both asserted.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = DW'(46'h300 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("t5_occ_half", 64'(occupancy), 64'd16);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 46'h3FF;
    step();
    chk_reset_state("t5_flush");
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("t5_occ_after", 64'(occupancy), 64'd0);
    chk("t5_ovf_after", 64'(wr_ovf),    64'd0);
    $display("T5 flush: checks=%0d failures=%0d", checks, failures);

    // T6: reset in the middle of a write burst at occupancy 10.
    wr_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_data = DW'(46'h400 + i);
      step();
    end
    chk("t6_occ_10", 64'(occupancy), 64'd10);
    rst = 1'b1;
    step();
    chk_reset_state("t6_rst");
    rst = 1'b0; wr_data = 46'hAB;
    step();
    wr_data = 46'hAC;
    step();
    wr_en = 1'b0;
    step();
    chk("t6_empty_n", 64'(empty_n), 64'd1);
    chk("t6_rd_ab",   64'(rd_data), 64'hAB);
    $display("T6 mid-burst reset: checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pcie_cmd_fwft_fifo
